// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing FSM.
// Holds the 3-bit state encoding, port addresses and the watchdog default.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_t;

    localparam logic [1:0] ADDR_P0  = 2'd0;
    localparam logic [1:0] ADDR_P1  = 2'd1;
    localparam logic [1:0] ADDR_P2  = 2'd2;
    localparam logic [1:0] ADDR_INV = 2'd3;

    localparam int unsigned WDOG_CYCLES_DEF = 30;

    // Per-port flag select; the invalid address never selects a port.
    function automatic logic port_sel(input logic [2:0] flags,
                                      input logic [1:0] addr);
        logic r;
        r = 1'b0;
        unique case (addr)
            ADDR_P0:  r = flags[0];
            ADDR_P1:  r = flags[1];
            ADDR_P2:  r = flags[2];
            ADDR_INV: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Status/strobe bundle between the router input side and router_fsm.
// master drives packet/FIFO status; slave is the FSM.
interface router_fsm_if;

    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic       busy;
    logic       wdog_timeout;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state,
        input  full_state, rst_int_reg, write_enb_reg,
        input  busy, wdog_timeout
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state,
        output full_state, rst_int_reg, write_enb_reg,
        output busy, wdog_timeout
    );

endinterface

// File: rtl/router_fsm_wdog.sv
// Stall watchdog: counts consecutive WTE/FFS cycles and flags the last one.
module router_fsm_wdog
    import router_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic stall,
    output logic timeout
);

    localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WDOG_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (stall) begin
            cnt <= cnt_inc;
        end else begin
            cnt <= '0;
        end
    end

    // Fires in the cycle whose edge brings the count to the limit.
    assign timeout = stall && (cnt_inc == LIMIT);

endmodule

// File: rtl/router_fsm.sv
// 1x3 router packet-sequencing FSM with Moore strobes for router_reg/FIFO.
// Optional stall watchdog enabled by defining ROUTER_FSM_WDOG_EN.
module router_fsm
    import router_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic         clock,
    input  logic         resetn,
    router_fsm_if.slave  bus
);

    router_state_t state;
    router_state_t nxt;
    logic [1:0]    addr_q;
    logic [2:0]    empties;
    logic [2:0]    softs;
    logic          empty_in;
    logic          empty_q;
    logic          srst_q;
    logic          wdog_hit;

    if (WDOG_CYCLES == 0) begin : g_bad_cfg
        $error("router_fsm: WDOG_CYCLES must be at least 1");
    end

    assign empties = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign softs   = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign empty_in = port_sel(empties, bus.data_in);
    assign empty_q  = port_sel(empties, addr_q);
    assign srst_q   = (state != DECODE_ADDRESS) && port_sel(softs, addr_q);

`ifdef ROUTER_FSM_WDOG_EN
    logic stall;

    assign stall = (state == WAIT_TILL_EMPTY) || (state == FIFO_FULL_STATE);

    router_fsm_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clock   (clock),
        .resetn  (resetn),
        .stall   (stall),
        .timeout (wdog_hit)
    );
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= ADDR_P0;
        end else begin
            state <= nxt;
            if (state == DECODE_ADDRESS && nxt != DECODE_ADDRESS) begin
                addr_q <= bus.data_in;
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && bus.data_in != ADDR_INV) begin
                    nxt = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_q) nxt = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       nxt = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        nxt = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) nxt = LOAD_PARITY;
                else                        nxt = LOAD_DATA;
            end
            LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
        endcase
        // Port soft reset outranks the watchdog abort.
        if (srst_q || wdog_hit) nxt = DECODE_ADDRESS;
    end

    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.busy          = 1'b1;
        unique case (state)
            DECODE_ADDRESS: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
            LOAD_FIRST_DATA: bus.lfd_state = 1'b1;
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b0;
            end
            WAIT_TILL_EMPTY: ;
            FIFO_FULL_STATE: bus.full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_PARITY:        bus.write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: bus.rst_int_reg   = 1'b1;
        endcase
    end

    assign bus.wdog_timeout = wdog_hit && !srst_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed vector bench for router_fsm: state walk, stalls, soft reset,
// asynchronous reset and the stall watchdog (ROUTER_FSM_WDOG_EN aware).
module tb_router_fsm;
    import router_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    router_fsm_if bus();

    router_fsm #(
        .WDOG_CYCLES (30)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    localparam router_state_t DA  = DECODE_ADDRESS;
    localparam router_state_t LFD = LOAD_FIRST_DATA;
    localparam router_state_t LD  = LOAD_DATA;
    localparam router_state_t WTE = WAIT_TILL_EMPTY;
    localparam router_state_t FFS = FIFO_FULL_STATE;
    localparam router_state_t LAF = LOAD_AFTER_FULL;
    localparam router_state_t LP  = LOAD_PARITY;
    localparam router_state_t CPE = CHECK_PARITY_ERROR;

    typedef struct {
        logic          pv;
        logic [1:0]    din;
        logic          full;
        logic [2:0]    emp;
        logic [2:0]    sr;
        logic          pd;
        logic          lpv;
        router_state_t st;
        logic [1:0]    aq;
    } vec_t;

    vec_t vecs[$];

    // {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy,wdog_timeout}
    function automatic logic [8:0] exp_outs(input router_state_t s);
        logic [8:0] r;
        case (s)
            DA:      r = 9'b100000000;
            LFD:     r = 9'b010000010;
            LD:      r = 9'b001000100;
            WTE:     r = 9'b000000010;
            FFS:     r = 9'b000010010;
            LAF:     r = 9'b000100110;
            LP:      r = 9'b000000110;
            default: r = 9'b000001010;
        endcase
        return r;
    endfunction

    function automatic logic [8:0] outs();
        return {bus.detect_add, bus.lfd_state, bus.ld_state,
                bus.laf_state, bus.full_state, bus.rst_int_reg,
                bus.write_enb_reg, bus.busy, bus.wdog_timeout};
    endfunction

    function automatic vec_t mk(input logic pv, input logic [1:0] din,
                                input logic full, input logic [2:0] emp,
                                input logic [2:0] sr, input logic pd,
                                input logic lpv, input router_state_t st,
                                input logic [1:0] aq);
        vec_t v;
        v.pv = pv; v.din = din; v.full = full; v.emp = emp;
        v.sr = sr; v.pd = pd; v.lpv = lpv; v.st = st; v.aq = aq;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.pkt_valid     = v.pv;
        bus.data_in       = v.din;
        bus.fifo_full     = v.full;
        bus.fifo_empty_0  = v.emp[0];
        bus.fifo_empty_1  = v.emp[1];
        bus.fifo_empty_2  = v.emp[2];
        bus.soft_reset_0  = v.sr[0];
        bus.soft_reset_1  = v.sr[1];
        bus.soft_reset_2  = v.sr[2];
        bus.parity_done   = v.pd;
        bus.low_pkt_valid = v.lpv;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [8:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s outs got=%b exp=%b", nm, outs(), exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic step(input string nm, input vec_t v);
        drive(v);
        tick();
        chk(nm, exp_outs(v.st));
    endtask

    int we_cnt;
    int wr_cnt;
    int n_ffs;
    int pulses;
    int pulse_at;

    initial begin
        // Packet 1: addr 1, two payload bytes, parity.
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD, 2'd1));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd1));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd1));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LP,  2'd1));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, CPE, 2'd1));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA,  2'd1));
        // Packet 2: addr 2 waits 4 cycles for FIFO 2 to drain.
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, WTE, 2'd2));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, WTE, 2'd2));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, WTE, 2'd2));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, WTE, 2'd2));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD, 2'd2));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd2));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LP,  2'd2));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, CPE, 2'd2));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA,  2'd2));
        // Invalid address 3 and idle: header dropped, addr_q kept.
        vecs.push_back(mk(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA,  2'd2));
        vecs.push_back(mk(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA,  2'd2));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA,  2'd2));
        // Packet 4: full stall, LAF->LP, CPE->FFS, LAF parity_done->DA.
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD, 2'd0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FFS, 2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FFS, 2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LAF, 2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, LP,  2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, CPE, 2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FFS, 2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LAF, 2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b1, DA,  2'd0));
        // Packet 5: LAF with nothing pending returns to LD.
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD, 2'd0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FFS, 2'd0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LAF, 2'd0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LP,  2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, CPE, 2'd0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA,  2'd0));
        // Soft reset: only the selected port counts, never in DA.
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD, 2'd1));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd1));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, LD,  2'd1));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, DA,  2'd1));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b111, 1'b0, 1'b0, LFD, 2'd0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, DA,  2'd0));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, WTE, 2'd2));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b011, 3'b011, 1'b0, 1'b0, WTE, 2'd2));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 3'b011, 3'b100, 1'b0, 1'b0, DA,  2'd2));

        drive(mk(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA, 2'd0));
        #12;
        chk("reset", exp_outs(DA));
        chk_int("reset addr_q", int'(dut.addr_q), 0);
        resetn = 1'b1;

        we_cnt = 0;
        wr_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
            chk_int($sformatf("vec%0d addr_q", i), int'(dut.addr_q),
                    int'(vecs[i].aq));
            if (i < 6) begin
                we_cnt += int'(bus.write_enb_reg);
                wr_cnt += int'(bus.write_enb_reg | bus.lfd_state);
            end
        end
        chk_int("pkt1 write_enb cycles", we_cnt, 3);
        chk_int("pkt1 byte writes", wr_cnt, 4);

        // Asynchronous reset in LAF.
        step("ar lfd", mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD, 2'd1));
        step("ar ld",  mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd1));
        step("ar ffs", mk(1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FFS, 2'd1));
        step("ar laf", mk(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LAF, 2'd1));
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset now", exp_outs(DA));
        chk_int("async reset addr_q", int'(dut.addr_q), 0);
        tick();
        chk("async reset held", exp_outs(DA));
        resetn = 1'b1;

        // Hold FIFO full in FFS.
        step("wd lfd", mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LFD, 2'd0));
        step("wd ld",  mk(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, LD,  2'd0));
        drive(mk(1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, FFS, 2'd0));
        tick();
        n_ffs = 0;
        pulses = 0;
        pulse_at = 0;
        for (int c = 0; c < 150 && bus.full_state; c++) begin
            n_ffs++;
            if (bus.wdog_timeout) begin
                pulses++;
                pulse_at = n_ffs;
            end
            if (c == 110) begin
                bus.soft_reset_0 = 1'b1;
            end
            tick();
        end
        bus.soft_reset_0 = 1'b0;
        chk("wd exit", exp_outs(DA));
`ifdef ROUTER_FSM_WDOG_EN
        chk_int("wd ffs cycles", n_ffs, 30);
        chk_int("wd pulses", pulses, 1);
        chk_int("wd pulse cycle", pulse_at, 30);
`else
        chk_int("no wd ffs cycles", n_ffs, 111);
        chk_int("no wd pulses", pulses, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
